// File: rtl/osc_meas_pkg.sv
// Shared definitions for the oscillator frequency meter slice.
//   meas_state_t : window state machine encoding (IDLE, COUNT)
//   lock_cnt_w() : bit width of a counter spanning 0..lock_n
//   err_w()      : width of the signed error word for a cw-bit count
package osc_meas_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } meas_state_t;

  // Width needed to hold 0..lock_n; never below one bit.
  function automatic int lock_cnt_w(input int lock_n);
    return (lock_n < 1) ? 1 : $clog2(lock_n + 1);
  endfunction

  // The error carries one extra bit so count - target never wraps.
  function automatic int err_w(input int cw);
    return cw + 1;
  endfunction

endpackage

// File: rtl/osc_freq_meter_if.sv
// Result bundle published by osc_freq_meter once per completed window.
//   count : last completed window count (CW bits)
//   err   : signed count - target (CW+1 bits)
//   valid : one-cycle strobe on the cycle the fields below first change
//   ovf   : last window saturated
//   up/dn : oscillator slow / fast beyond tolerance
//   lock  : frequency lock indicator
// Modports: master (meter drives), slave (consumer reads).
interface osc_freq_meter_if
  import osc_meas_pkg::*;
#(
  parameter int CW = 16
) ();

  logic [CW-1:0]               count;
  logic signed [err_w(CW)-1:0] err;
  logic                        valid;
  logic                        ovf;
  logic                        up;
  logic                        dn;
  logic                        lock;

  modport master (output count, err, valid, ovf, up, dn, lock);
  modport slave  (input  count, err, valid, ovf, up, dn, lock);

endinterface

// File: rtl/ref_edge_sync.sv
// Brings the asynchronous reference clock into the ck domain and flags
// its rising edges.
//   ck       : oscillator clock (rising edge)
//   rst      : asynchronous active-high reset, all flops clear to 0
//   refclk   : reference clock, asynchronous to ck
//   ref_rise : one-cycle pulse per detected reference rising edge
module ref_edge_sync (
  input  logic ck,
  input  logic rst,
  input  logic refclk,
  output logic ref_rise
);

  logic s1, s2, s3;

  // s1/s2 form the metastability synchronizer and s3 holds the previous
  // synchronized level. The edge pulse s2 & ~s3 is itself registered so
  // the consumer sees a flop output; this places ref_rise two cycles after
  // the first ck edge that samples refclk high.
  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      s1       <= 1'b0;
      s2       <= 1'b0;
      s3       <= 1'b0;
      ref_rise <= 1'b0;
    end else begin
      s1       <= refclk;
      s2       <= s1;
      s3       <= s2;
      ref_rise <= s2 & ~s3;
    end
  end

endmodule

// File: rtl/osc_freq_meter.sv
// Frequency meter running on the oscillator clock: counts ck cycles
// between successive reference rising edges and reports the count, the
// signed error against TARGET, up/dn steering flags and saturation.
//   ck     : oscillator clock (all flops, rising edge)
//   rst    : asynchronous active-high reset
//   refclk : reference clock, asynchronous to ck ("ref" is a keyword)
//   res    : osc_freq_meter_if.master result bundle
// Optional lock detector compiled in with `define OSC_FREQ_METER_LOCK_EN;
// without it res.lock is tied low.
module osc_freq_meter
  import osc_meas_pkg::*;
#(
  parameter int CW     = 16,
  parameter int TARGET = 150,
  parameter int TOL    = 2,
  parameter int LOCK_N = 4
) (
  input  logic             ck,
  input  logic             rst,
  input  logic             refclk,
  osc_freq_meter_if.master res
);

  localparam int EW = err_w(CW);
  localparam logic [CW-1:0]        CNT_MAX  = '1;
  localparam logic signed [EW-1:0] TARGET_S = EW'(TARGET);
  localparam logic signed [EW-1:0] TOL_S    = EW'(TOL);

  meas_state_t              state, state_n;
  logic [CW-1:0]            cnt, cnt_n;
  logic                     sat, sat_n;
  logic                     done;
  logic                     ref_rise;
  logic                     ovf_n, up_n, dn_n;
  logic signed [EW-1:0]     err_n;

  ref_edge_sync u_sync (
    .ck       (ck),
    .rst      (rst),
    .refclk   (refclk),
    .ref_rise (ref_rise)
  );

  // State, window counter and sticky saturation flag.
  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      sat   <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      sat   <= sat_n;
    end
  end

  // The first reference edge after reset only opens a window; every later
  // edge closes the running window (done) and opens the next one with the
  // edge cycle itself counted as 1. The counter sticks at all-ones and the
  // sticky flag remembers that it got there.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    sat_n   = sat;
    done    = 1'b0;
    case (state)
      IDLE: begin
        if (ref_rise) begin
          state_n = COUNT;
          cnt_n   = CW'(1);
          sat_n   = 1'b0;
        end
      end
      COUNT: begin
        if (ref_rise) begin
          done  = 1'b1;
          cnt_n = CW'(1);
          sat_n = 1'b0;
        end else begin
          if (cnt != CNT_MAX) cnt_n = cnt + 1'b1;
          if (cnt_n == CNT_MAX) sat_n = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Result of the window closing this cycle. Saturation overrides the
  // tolerance compare so a hopelessly fast oscillator always steers down.
  always_comb begin
    ovf_n = sat | (cnt == CNT_MAX);
    err_n = $signed({1'b0, cnt}) - TARGET_S;
    up_n  = (err_n < -TOL_S) & ~ovf_n;
    dn_n  = (err_n > TOL_S) | ovf_n;
  end

  // Output registers: all fields change together on a window completion
  // and valid marks exactly that cycle.
  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      res.count <= '0;
      res.err   <= -TARGET_S;
      res.valid <= 1'b0;
      res.ovf   <= 1'b0;
      res.up    <= 1'b0;
      res.dn    <= 1'b0;
    end else begin
      res.valid <= done;
      if (done) begin
        res.count <= cnt;
        res.err   <= err_n;
        res.ovf   <= ovf_n;
        res.up    <= up_n;
        res.dn    <= dn_n;
      end
    end
  end

`ifdef OSC_FREQ_METER_LOCK_EN
  localparam int LW = lock_cnt_w(LOCK_N);
  localparam logic [LW-1:0] LOCK_MAX = LW'(LOCK_N);

  logic [LW-1:0] lock_cnt, lock_cnt_n;
  logic          lock_q;
  logic          intol;

  // Count consecutive good windows; a single bad window drops it to zero.
  always_comb begin
    intol      = ~ovf_n & (err_n >= -TOL_S) & (err_n <= TOL_S);
    lock_cnt_n = lock_cnt;
    if (done) begin
      if (!intol)                   lock_cnt_n = '0;
      else if (lock_cnt != LOCK_MAX) lock_cnt_n = lock_cnt + 1'b1;
    end
  end

  // lock is registered from the next count so it moves on the same edge
  // as the window result.
  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      lock_cnt <= '0;
      lock_q   <= 1'b0;
    end else begin
      lock_cnt <= lock_cnt_n;
      lock_q   <= (lock_cnt_n == LOCK_MAX);
    end
  end

  assign res.lock = lock_q;
`else
  assign res.lock = 1'b0;
`endif

endmodule

// File: tb/tb_osc_freq_meter.sv
// Self-checking bench for osc_freq_meter. Two instances (CW=16 and CW=8)
// see the same reference stimulus; a behavioural model derives each
// window's expected result from the period the bench generated.
module tb_osc_freq_meter;
  import osc_meas_pkg::*;

  localparam int TARGET = 150;
  localparam int TOL    = 2;
  localparam int LOCK_N = 4;
`ifdef OSC_FREQ_METER_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  typedef struct packed {
    logic [15:0]        count;
    logic signed [16:0] err;
    logic               ovf;
    logic               up;
    logic               dn;
    logic               lock;
  } res_t;

  logic ck = 1'b0;
  logic rst = 1'b0;
  logic refclk = 1'b0;

  int   checks = 0;
  int   failures = 0;

  always #5 ck = ~ck;

  osc_freq_meter_if #(.CW(16)) if16 ();
  osc_freq_meter_if #(.CW(8))  if8 ();

  osc_freq_meter #(.CW(16), .TARGET(TARGET), .TOL(TOL), .LOCK_N(LOCK_N)) dut16 (
    .ck(ck), .rst(rst), .refclk(refclk), .res(if16)
  );
  osc_freq_meter #(.CW(8), .TARGET(TARGET), .TOL(TOL), .LOCK_N(LOCK_N)) dut8 (
    .ck(ck), .rst(rst), .refclk(refclk), .res(if8)
  );

  // Model state: period of the window currently open (-1: none since reset)
  // and the consecutive-good-window count per instance.
  int   prev_p = -1;
  int   lk16 = 0;
  int   lk8 = 0;
  res_t o16, o8, e16, e8, rst_res;
  int   nv16, nv8, pos16, exp_nv;

  function automatic res_t snap16();
    res_t r;
    r.count = if16.count;
    r.err   = if16.err;
    r.ovf   = if16.ovf;
    r.up    = if16.up;
    r.dn    = if16.dn;
    r.lock  = if16.lock;
    return r;
  endfunction

  function automatic res_t snap8();
    res_t r;
    r.count = {8'd0, if8.count};
    r.err   = {{8{if8.err[8]}}, if8.err};
    r.ovf   = if8.ovf;
    r.up    = if8.up;
    r.dn    = if8.dn;
    r.lock  = if8.lock;
    return r;
  endfunction

  // Expected result of a window of p ck cycles on a cw-bit meter.
  function automatic res_t model(input int p, input int cw, inout int lockc);
    res_t r;
    int   mx = (1 << cw) - 1;
    int   c  = (p > mx) ? mx : p;
    int   e  = c - TARGET;
    bit   o  = (p >= mx);
    r.count = 16'(c);
    r.err   = 17'(e);
    r.ovf   = o;
    r.up    = !o && (e < -TOL);
    r.dn    = o || (e > TOL);
    if (!o && e >= -TOL && e <= TOL) lockc = (lockc < LOCK_N) ? lockc + 1 : LOCK_N;
    else                             lockc = 0;
    r.lock  = LOCK_EN && (lockc == LOCK_N);
    return r;
  endfunction

  // One reference period of p ck cycles starting at a negedge; records the
  // valid pulses seen and the outputs on the valid cycle.
  task automatic drive_window(input int p);
    refclk = 1'b1;
    nv16 = 0; nv8 = 0; pos16 = 0; o16 = '0; o8 = '0;
    for (int i = 1; i <= p; i++) begin
      @(negedge ck);
      if (if16.valid === 1'b1) begin
        nv16++;
        if (pos16 == 0) pos16 = i;
        o16 = snap16();
      end
      if (if8.valid === 1'b1) begin
        nv8++;
        o8 = snap8();
      end
      if (i == p / 2) refclk = 1'b0;
    end
  endtask

  // Drive a period and compute what the window it closes should report.
  task automatic step(input int p);
    drive_window(p);
    if (prev_p < 0) begin
      exp_nv = 0;
      e16 = '0;
      e8  = '0;
    end else begin
      exp_nv = 1;
      e16 = model(prev_p, 16, lk16);
      e8  = model(prev_p, 8, lk8);
    end
    prev_p = p;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge ck);
    checks++;
    if (snap16() !== rst_res || if16.valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset16 got=%h valid=%b exp=%h valid=0", snap16(), if16.valid, rst_res);
    end
    checks++;
    if (snap8() !== rst_res || if8.valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset8 got=%h valid=%b exp=%h valid=0", snap8(), if8.valid, rst_res);
    end
    rst = 1'b0;
    prev_p = -1; lk16 = 0; lk8 = 0;
    repeat (2) @(negedge ck);
  endtask

  task automatic test_steady();
    for (int k = 0; k < 6; k++) begin
      step(150);
      checks++;
      if (nv16 !== exp_nv || nv8 !== exp_nv) begin
        failures++;
        $display("[TB] FAIL steady_valid k=%0d got=%0d/%0d exp=%0d", k, nv16, nv8, exp_nv);
      end
      if (exp_nv == 1) begin
        checks++;
        if (pos16 !== 4) begin
          failures++;
          $display("[TB] FAIL steady_latency k=%0d got=%0d exp=4", k, pos16);
        end
        checks++;
        if (o16 !== e16 || o8 !== e8) begin
          failures++;
          $display("[TB] FAIL steady_result k=%0d got=%h/%h exp=%h/%h", k, o16, o8, e16, e8);
        end
      end
    end
    checks++;
    if (o16.count !== 16'd150 || o16.err !== 17'sd0 || o16.up !== 1'b0 || o16.dn !== 1'b0
        || o16.lock !== LOCK_EN) begin
      failures++;
      $display("[TB] FAIL steady_final got=%h exp count=150 err=0 up=dn=0 lock=%b", o16, LOCK_EN);
    end
  endtask

  task automatic test_slow();
    for (int k = 0; k < 3; k++) begin
      step(140);
      checks++;
      if (nv16 !== exp_nv || o16 !== e16 || o8 !== e8) begin
        failures++;
        $display("[TB] FAIL slow k=%0d got=%0d %h/%h exp=%0d %h/%h", k, nv16, o16, o8, exp_nv, e16, e8);
      end
    end
    checks++;
    if (o16.count !== 16'd140 || o16.err !== -17'sd10 || o16.up !== 1'b1 || o16.dn !== 1'b0
        || o16.lock !== 1'b0) begin
      failures++;
      $display("[TB] FAIL slow_final got=%h exp count=140 err=-10 up=1 dn=0 lock=0", o16);
    end
  endtask

  task automatic test_boundary();
    int per[5] = '{148, 152, 147, 153, 150};
    for (int k = 0; k < 5; k++) begin
      step(per[k]);
      checks++;
      if (nv16 !== exp_nv || o16 !== e16 || o8 !== e8) begin
        failures++;
        $display("[TB] FAIL boundary p=%0d got=%0d %h/%h exp=%0d %h/%h", per[k], nv16, o16, o8, exp_nv, e16, e8);
      end
    end
  endtask

  task automatic test_lock();
    int per[11] = '{150, 150, 150, 150, 150, 160, 150, 150, 150, 150, 150};
    for (int k = 0; k < 11; k++) begin
      step(per[k]);
      checks++;
      if (nv16 !== exp_nv || o16 !== e16 || o8 !== e8) begin
        failures++;
        $display("[TB] FAIL lock k=%0d got=%0d %h/%h exp=%0d %h/%h", k, nv16, o16, o8, exp_nv, e16, e8);
      end
    end
  endtask

  task automatic test_ovf();
    int per[8] = '{150, 150, 150, 150, 150, 300, 150, 150};
    for (int k = 0; k < 8; k++) begin
      step(per[k]);
      checks++;
      if (nv8 !== exp_nv || o16 !== e16 || o8 !== e8) begin
        failures++;
        $display("[TB] FAIL ovf k=%0d got=%0d %h/%h exp=%0d %h/%h", k, nv8, o16, o8, exp_nv, e16, e8);
      end
      if (k == 6) begin
        checks++;
        if (o8.count !== 16'd255 || o8.ovf !== 1'b1 || o8.dn !== 1'b1 || o8.up !== 1'b0
            || o8.lock !== 1'b0) begin
          failures++;
          $display("[TB] FAIL ovf_sat8 got=%h exp count=255 ovf=1 dn=1 up=0 lock=0", o8);
        end
      end
    end
    checks++;
    if (o8.ovf !== 1'b0 || o8.count !== 16'd150) begin
      failures++;
      $display("[TB] FAIL ovf_clear8 got=%h exp count=150 ovf=0", o8);
    end
  endtask

  task automatic test_mid_reset();
    refclk = 1'b1;
    for (int i = 1; i <= 100; i++) begin
      @(negedge ck);
      if (i == 75) refclk = 1'b0;
    end
    rst = 1'b1;
    #1;
    checks++;
    if (snap16() !== rst_res || if16.valid !== 1'b0 || snap8() !== rst_res) begin
      failures++;
      $display("[TB] FAIL midreset_outputs got=%h/%h exp=%h", snap16(), snap8(), rst_res);
    end
    repeat (2) @(negedge ck);
    rst = 1'b0;
    repeat (48) @(negedge ck);
    prev_p = -1; lk16 = 0; lk8 = 0;
    for (int k = 0; k < 3; k++) begin
      step(150);
      checks++;
      if (nv16 !== exp_nv || nv8 !== exp_nv || o16 !== e16 || o8 !== e8) begin
        failures++;
        $display("[TB] FAIL midreset k=%0d got=%0d %h/%h exp=%0d %h/%h", k, nv16, o16, o8, exp_nv, e16, e8);
      end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 14; k++) begin
      int p = $urandom_range(320, 120);
      step(p);
      checks++;
      if (nv16 !== exp_nv || nv8 !== exp_nv || o16 !== e16 || o8 !== e8) begin
        failures++;
        $display("[TB] FAIL random p=%0d got=%0d %h/%h exp=%0d %h/%h", p, nv16, o16, o8, exp_nv, e16, e8);
      end
    end
  endtask

  initial begin
    rst_res = '0;
    rst_res.err = -17'sd150;
    @(negedge ck);
    test_reset();
    test_steady();
    test_slow();
    test_boundary();
    test_lock();
    test_ovf();
    test_mid_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
